// File: rtl/serial_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_alu_pkg
// Description : Shared opcodes, FSM state encoding and opcode legality helper
//               for the bit-serial ALU issue/collect stage.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_alu_pkg;

   // ALU opcodes; OP_RST also clears the ALU's internal bit counter.
   localparam logic [2:0] OP_RST = 3'b000;
   localparam logic [2:0] OP_XOR = 3'b001;
   localparam logic [2:0] OP_SUB = 3'b100;

   // Sequencer FSM states
   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] CLEAR   = 3'd1;
   localparam logic [2:0] RUN     = 3'd2;
   localparam logic [2:0] CAPTURE = 3'd3;
   localparam logic [2:0] DONE    = 3'd4;

   function automatic logic is_legal_op(input logic [2:0] op);
      return (op == OP_XOR) || (op == OP_SUB);
   endfunction

endpackage
`default_nettype wire

// File: rtl/serial_alu_sequencer_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : cmd_fifo
// Description : Synchronous command FIFO with registered occupancy count.
//               Pushes while full and pops while empty are ignored, so a
//               push can never overwrite live data even with a concurrent pop.
// Ports       : clk, reset       - clock, asynchronous active-high reset
//               push_i, wr_data_i - write strobe and data
//               pop_i, rd_data_o  - read strobe and head-of-queue data
//               full_o, empty_o   - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module cmd_fifo #(
   parameter int DATA_W     = 11,
   parameter int FIFO_DEPTH = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic              pop_i,
   output logic [DATA_W-1:0] rd_data_o,
   output logic              full_o,
   output logic              empty_o
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q;
   logic [PTR_W-1:0]  rd_ptr_q;
   logic [CNT_W-1:0]  count_q;
   logic              do_push;
   logic              do_pop;

   assign full_o    = (count_q == DEPTH_C);
   assign empty_o   = (count_q == '0);
   assign do_push   = push_i && !full_o;
   assign do_pop    = pop_i && !empty_o;
   assign rd_data_o = mem_q[rd_ptr_q];

   // Pointers wrap naturally because the depth is a power of two.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage carries no reset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
   end

endmodule
`default_nettype wire

// File: rtl/serial_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : serial_alu_sequencer
// Description : Issue/collect stage for the bit-serial ALU. Buffers commands,
//               clears the ALU, runs it for WIDTH cycles with stable operands,
//               captures result/flags and hands them downstream.
// Ports       : clk, reset                 - clock, async active-high reset
//               in_valid/in_ready/in_a/in_b/in_op - upstream command channel
//               alu_srcA/alu_srcB/alu_opCode     - ALU drive
//               alu_result/alu_zero/alu_carry/alu_sign - ALU returns
//               out_valid/out_ready/out_*         - downstream result channel
//               busy                              - work pending or in flight
// Revision    : 1.0 - initial release
// ============================================================================
module serial_alu_sequencer
   import serial_alu_pkg::*;
#(
   parameter int WIDTH      = 4,
   parameter int FIFO_DEPTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [2:0]       in_op,
   output logic [WIDTH-1:0] alu_srcA,
   output logic [WIDTH-1:0] alu_srcB,
   output logic [2:0]       alu_opCode,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_zero,
   input  logic             alu_carry,
   input  logic             alu_sign,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_zero,
   output logic             out_carry,
   output logic             out_sign,
   output logic [2:0]       out_op,
   output logic             out_err,
   output logic             busy
);

   localparam int DATA_W = 2 * WIDTH + 3;
   localparam int CNT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   logic              fifo_full;
   logic              fifo_empty;
   logic              fifo_pop;
   logic [DATA_W-1:0] fifo_head;
   logic [WIDTH-1:0]  head_a;
   logic [WIDTH-1:0]  head_b;
   logic [2:0]        head_op;

   logic [2:0]        state_q,  state_d;
   logic [CNT_W-1:0]  cnt_q,    cnt_d;
   logic [WIDTH-1:0]  a_q,      a_d;
   logic [WIDTH-1:0]  b_q,      b_d;
   logic [2:0]        op_q,     op_d;
   logic              ovalid_q, ovalid_d;
   logic [WIDTH-1:0]  ores_q,   ores_d;
   logic              ozero_q,  ozero_d;
   logic              ocarry_q, ocarry_d;
   logic              osign_q,  osign_d;
   logic [2:0]        oop_q,    oop_d;
   logic              oerr_q,   oerr_d;

   cmd_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_cmd_fifo (
      .clk       (clk),
      .reset     (reset),
      .push_i    (in_valid),
      .wr_data_i ({in_a, in_b, in_op}),
      .pop_i     (fifo_pop),
      .rd_data_o (fifo_head),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty)
   );

   assign head_a  = fifo_head[DATA_W-1 -: WIDTH];
   assign head_b  = fifo_head[WIDTH+2 -: WIDTH];
   assign head_op = fifo_head[2:0];

   assign in_ready   = !fifo_full;
   assign busy       = (state_q != IDLE) || !fifo_empty;
   // Operands come straight from the op register, which only loads on a pop,
   // so they cannot move while the ALU is running.
   assign alu_srcA   = a_q;
   assign alu_srcB   = b_q;
   assign alu_opCode = (state_q == RUN) ? op_q : OP_RST;

   assign out_valid  = ovalid_q;
   assign out_result = ores_q;
   assign out_zero   = ozero_q;
   assign out_carry  = ocarry_q;
   assign out_sign   = osign_q;
   assign out_op     = oop_q;
   assign out_err    = oerr_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      a_d      = a_q;
      b_d      = b_q;
      op_d     = op_q;
      ovalid_d = ovalid_q;
      ores_d   = ores_q;
      ozero_d  = ozero_q;
      ocarry_d = ocarry_q;
      osign_d  = osign_q;
      oop_d    = oop_q;
      oerr_d   = oerr_q;
      fifo_pop = 1'b0;

      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               a_d      = head_a;
               b_d      = head_b;
               op_d     = head_op;
               if (is_legal_op(head_op)) begin
                  state_d = CLEAR;
               end else begin
                  // Illegal opcodes are reported without touching the ALU.
                  state_d  = DONE;
                  ovalid_d = 1'b1;
                  ores_d   = '0;
                  ozero_d  = 1'b0;
                  ocarry_d = 1'b0;
                  osign_d  = 1'b0;
                  oop_d    = head_op;
                  oerr_d   = 1'b1;
               end
            end
         end
         CLEAR: begin
            state_d = RUN;
            cnt_d   = '0;
         end
         RUN: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) state_d = CAPTURE;
         end
         CAPTURE: begin
            // ALU sees OP_RST this cycle but still holds its last result.
            state_d  = DONE;
            ovalid_d = 1'b1;
            ores_d   = alu_result;
            ozero_d  = alu_zero;
            ocarry_d = alu_carry;
            osign_d  = alu_sign;
            oop_d    = op_q;
            oerr_d   = 1'b0;
         end
         DONE: begin
            if (out_ready) begin
               ovalid_d = 1'b0;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= OP_RST;
         ovalid_q <= 1'b0;
         ores_q   <= '0;
         ozero_q  <= 1'b0;
         ocarry_q <= 1'b0;
         osign_q  <= 1'b0;
         oop_q    <= 3'b000;
         oerr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         a_q      <= a_d;
         b_q      <= b_d;
         op_q     <= op_d;
         ovalid_q <= ovalid_d;
         ores_q   <= ores_d;
         ozero_q  <= ozero_d;
         ocarry_q <= ocarry_d;
         osign_q  <= osign_d;
         oop_q    <= oop_d;
         oerr_q   <= oerr_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_serial_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_alu_sequencer
// Description : Scoreboard bench for serial_alu_sequencer with a bit-serial
//               ALU model attached. Expected results are hand-computed and
//               queued at command acceptance; a monitor pops on each
//               downstream handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_alu_sequencer;

   typedef struct {
      logic [3:0] r;
      logic       z;
      logic       c;
      logic       s;
      logic [2:0] op;
      logic       e;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_a, in_b;
   logic [2:0] in_op;
   logic [3:0] alu_srcA, alu_srcB;
   logic [2:0] alu_opCode;
   logic [3:0] alu_result;
   logic       alu_zero, alu_carry, alu_sign;
   logic       out_valid, out_ready;
   logic [3:0] out_result;
   logic       out_zero, out_carry, out_sign;
   logic [2:0] out_op;
   logic       out_err, busy;

   int   tests = 0;
   int   fails = 0;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   serial_alu_sequencer #(.WIDTH(4), .FIFO_DEPTH(2)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_op(in_op),
      .alu_srcA(alu_srcA), .alu_srcB(alu_srcB), .alu_opCode(alu_opCode),
      .alu_result(alu_result), .alu_zero(alu_zero),
      .alu_carry(alu_carry), .alu_sign(alu_sign),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_zero(out_zero),
      .out_carry(out_carry), .out_sign(out_sign),
      .out_op(out_op), .out_err(out_err), .busy(busy)
   );

   // Bit-serial ALU model: one result bit per clock, opcode 000 resets the
   // bit counter and borrow but keeps the last result.
   logic [1:0] m_cnt    = 2'd0;
   logic [3:0] m_res    = 4'd0;
   logic       m_borrow = 1'b0;
   logic [2:0] m_lastop = 3'b000;

   always @(posedge clk) begin
      if (alu_opCode == 3'b000) begin
         m_cnt    <= 2'd0;
         m_borrow <= 1'b0;
      end else begin
         m_lastop <= alu_opCode;
         m_cnt    <= m_cnt + 2'd1;
         if (alu_opCode == 3'b001) begin
            m_res[m_cnt] <= alu_srcA[m_cnt] ^ alu_srcB[m_cnt];
         end else if (alu_opCode == 3'b100) begin
            m_res[m_cnt] <= alu_srcA[m_cnt] ^ alu_srcB[m_cnt] ^ m_borrow;
            m_borrow     <= (~alu_srcA[m_cnt] & alu_srcB[m_cnt]) |
                            (~(alu_srcA[m_cnt] ^ alu_srcB[m_cnt]) & m_borrow);
         end
      end
   end

   assign alu_result = m_res;
   assign alu_zero   = (m_res == 4'd0);
   assign alu_sign   = m_res[3];
   assign alu_carry  = (m_lastop == 3'b100) ? ~m_borrow : 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Monitor: compares on every downstream handshake.
   always @(negedge clk) begin
      if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_result: got result %0h op %0h with no command pending",
                     out_result, out_op);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("out_result", 32'(out_result), 32'(e.r));
            chk("out_zero",   32'(out_zero),   32'(e.z));
            chk("out_carry",  32'(out_carry),  32'(e.c));
            chk("out_sign",   32'(out_sign),   32'(e.s));
            chk("out_op",     32'(out_op),     32'(e.op));
            chk("out_err",    32'(out_err),    32'(e.e));
         end
      end
   end

   task automatic push(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                       input logic [3:0] r, input logic z, input logic c,
                       input logic s, input logic e);
      int   waited;
      exp_t x;
      waited = 0;
      @(negedge clk);
      in_valid = 1'b1; in_a = a; in_b = b; in_op = op;
      while (!in_ready && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) begin
         chk("push_timeout", 32'(in_ready), 32'd1);
         in_valid = 1'b0;
         return;
      end
      x.r = r; x.z = z; x.c = c; x.s = s; x.op = op; x.e = e;
      exp_q.push_back(x);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || busy) && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("drain", 32'(exp_q.size()), 32'd0);
   endtask

   logic [2:0] t1_op [7];
   int         seen;

   initial begin
      t1_op = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b001, 3'b001, 3'b000};
      reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; out_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready",  32'(in_ready),  32'd1);
      chk("rst_busy",      32'(busy),      32'd0);
      chk("rst_opcode",    32'(alu_opCode), 32'd0);
      chk("rst_srcA",      32'(alu_srcA),  32'd0);
      chk("rst_srcB",      32'(alu_srcB),  32'd0);
      chk("rst_result",    32'({out_result, out_op, out_zero, out_carry, out_sign, out_err}), 32'd0);
      reset = 1'b0;

      // XOR 1010^0110 with cycle-exact opcode sequence and latency
      push(4'b1010, 4'b0110, 3'b001, 4'b1100, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (k < 7) chk($sformatf("t1_opcode_c%0d", k), 32'(alu_opCode), 32'(t1_op[k]));
         chk($sformatf("t1_valid_c%0d", k), 32'(out_valid), (k == 7) ? 32'd1 : 32'd0);
         if (k >= 2 && k <= 5) chk($sformatf("t1_srcA_c%0d", k), 32'(alu_srcA), 32'b1010);
      end
      drain();

      push(4'b0101, 4'b0101, 3'b001, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
      drain();
      push(4'b0101, 4'b0011, 3'b100, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b0);
      drain();

      // Backpressure: three commands, downstream stalled
      out_ready = 1'b0;
      push(4'b1111, 4'b0001, 3'b001, 4'b1110, 1'b0, 1'b0, 1'b1, 1'b0);
      push(4'b1000, 4'b0001, 3'b100, 4'b0111, 1'b0, 1'b1, 1'b0, 1'b0);
      push(4'b0011, 4'b0011, 3'b001, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      chk("bp_in_ready_full", 32'(in_ready), 32'd0);
      seen = 0;
      while (!out_valid && seen < 50) begin
         @(negedge clk);
         seen++;
      end
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("bp_hold_valid",  32'(out_valid),  32'd1);
         chk("bp_hold_result", 32'(out_result), 32'b1110);
         chk("bp_hold_ready",  32'(in_ready),   32'd0);
      end
      out_ready = 1'b1;
      drain();

      // Illegal opcode
      push(4'b1111, 4'b0000, 3'b010, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk($sformatf("ill_valid_c%0d", k), 32'(out_valid), (k == 1) ? 32'd1 : 32'd0);
         chk($sformatf("ill_opcode_c%0d", k), 32'(alu_opCode), 32'd0);
      end
      drain();

      // Reset during the third RUN cycle with one command queued
      push(4'b0101, 4'b0011, 3'b100, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b0);
      push(4'b1111, 4'b0001, 3'b001, 4'b1110, 1'b0, 1'b0, 1'b1, 1'b0);
      repeat (4) @(negedge clk);
      chk("mid_run_opcode", 32'(alu_opCode), 32'b100);
      #2 reset = 1'b1;
      exp_q.delete();
      #1;
      chk("mrst_out_valid", 32'(out_valid),  32'd0);
      chk("mrst_opcode",    32'(alu_opCode), 32'd0);
      chk("mrst_in_ready",  32'(in_ready),   32'd1);
      chk("mrst_busy",      32'(busy),       32'd0);
      @(negedge clk);
      #2 reset = 1'b0;
      seen = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      chk("post_reset_no_result", 32'(seen), 32'd0);
      chk("post_reset_busy", 32'(busy), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
